axi_wr_route_ctrl: RTL and testbench
====================================

Name: axi_wr_route_ctrl

Overview:
Write-channel routing controller for a 1-master to 2-slave AXI4 write path.
- Decodes AWADDR and drives the select inputs of the external 1-to-2 demux instances on the AW and W buses.
- Sequences AW/W/B valid-ready handshakes to the selected slave.
- Answers unmapped addresses internally with DECERR.
- One transaction in flight. Sits between the master-side write port and the two slave ports in the interconnect datapath.

Parameters:
ADDR_WIDTH, 32, AWADDR width
S0_BASE, 32'h0000_0000, slave 0 base; hit if (addr & S0_MASK) == S0_BASE
S0_MASK, 32'hF000_0000, slave 0 decode mask
S1_BASE, 32'h4000_0000, slave 1 base
S1_MASK, 32'hF000_0000, slave 1 decode mask
CNT_WIDTH, 16, status counter width

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
s_awaddr  in  ADDR_WIDTH  master write address
s_awvalid  in  1  master AW valid
s_awready  out  1  master AW ready
s_wvalid  in  1  master W valid
s_wlast  in  1  master last beat
s_wready  out  1  master W ready
s_bvalid  out  1  master B valid
s_bready  in  1  master B ready
s_bresp  out  2  master B response
m_awvalid  out  2  per-slave AW valid, bit i = slave i
m_awready  in  2  per-slave AW ready
m_wvalid  out  2  per-slave W valid
m_wready  in  2  per-slave W ready
m_bvalid  in  2  per-slave B valid
m_bready  out  2  per-slave B ready
m_bresp  in  4  per-slave B response, [2i+1:2i] = slave i
route_sel  out  1  select for AW/W demux instances (0 = slave 0)
busy  out  1  state != IDLE
txn_count  out  CNT_WIDTH  completed B handshakes, wraps
decerr_count  out  CNT_WIDTH  DECERR responses issued, wraps

Behaviour:
- Reset (ARESETN low, async):
  - state = IDLE, route_sel = 0, tgt_err = 0, counters = 0.
  - All valid/ready outputs 0, s_bresp = 0.
  - Mid-transaction reset aborts silently; no partial handshake completes.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - s_awready = 0.
  - On s_awvalid, register the decode result:
    - S0 hit → route_sel = 0.
    - Else S1 hit → route_sel = 1.
    - Else tgt_err = 1, route_sel = 0.
    - Both hit → slave 0 wins.
  - Next state ADDR. Decode latency is 1 cycle.
- ADDR:
  - Mapped target: m_awvalid[route_sel] = 1 and s_awready = m_awready[route_sel], combinational.
  - DECERR: s_awready = 1, no m_awvalid.
  - m_awvalid is held until the handshake completes.
  - On s_awvalid & s_awready → DATA.
- DATA:
  - Mapped target: m_wvalid[route_sel] = s_wvalid and s_wready = m_wready[route_sel].
  - DECERR: s_wready = 1; beats are sunk.
  - On a beat with s_wlast accepted → RESP.
- RESP:
  - Mapped target: s_bvalid = m_bvalid[route_sel], m_bready[route_sel] = s_bready, s_bresp = m_bresp slice.
  - DECERR: s_bvalid = 1 and s_bresp = 2'b11, held until s_bready.
  - On handshake: txn_count++, decerr_count++ if tgt_err, clear tgt_err → IDLE.
- Outside the owning state, every s_*ready, s_bvalid, m_* valid/ready is 0. The non-selected slave's signals are always 0.
- route_sel changes only in IDLE and is stable from ADDR through RESP.
- W beats presented before the AW is accepted stall (s_wready = 0). This is AXI-legal.
- A stray m_bvalid from the unselected slave, or outside RESP, is ignored and not acknowledged.
- Counters wrap at 2^CNT_WIDTH with no saturation.
- Throughput: minimum 4 cycles per single-beat transaction (IDLE, ADDR, DATA, RESP).

Decomposition:
- Package axi_ic_pkg holds:
  - typedef enum logic [1:0] wr_route_state_t {IDLE, ADDR, DATA, RESP}.
  - localparam RESP_OKAY = 2'b00, RESP_DECERR = 2'b11.
- One sub-module, axi_addr_decode_2s: combinational base/mask match returning {hit, sel}. It is reused by the future read-side controller.

Test Plan:
- awaddr 0x0000_1000, awlen 3 (4 beats, slaves always ready, bresp OKAY): route_sel = 0, m_awvalid = 01, 4 beats on m_wvalid[0], s_bresp = 00, txn_count = 1.
- awaddr 0x4000_0020, single beat, m_awready[1] low for 3 cycles: m_awvalid[1] held 3 cycles, s_awready low until accept, route_sel = 1 throughout, m_*[0] stay 0.
- awaddr 0x8000_0000, 2 beats: no m_* activity, both beats accepted, s_bvalid with s_bresp = 11, decerr_count = 1.
- s_wvalid asserted 2 cycles before s_awvalid, then s_bready low 5 cycles in RESP: s_wready = 0 until DATA, s_bvalid/s_bresp stable 5 cycles, m_bready[sel] follows s_bready.
- ARESETN pulsed low during DATA, mid-burst: all outputs 0 immediately (async), counters = 0. A new write to slave 1 completes normally afterwards.
- 2^CNT_WIDTH + 1 transactions (CNT_WIDTH overridden to 4): txn_count wraps to 1.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// -----------------------------------------------------------------------------
// axi_ic_pkg
// Shared types and constants for the AXI interconnect control blocks.
//   wr_route_state_t : write-routing controller phase (IDLE/ADDR/DATA/RESP)
//   RESP_OKAY        : AXI OKAY response code
//   RESP_DECERR      : AXI DECERR response code, used for unmapped addresses
// -----------------------------------------------------------------------------
package axi_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_route_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_addr_decode_2s.sv
// -----------------------------------------------------------------------------
// axi_addr_decode_2s
// Combinational base/mask address decoder for a two-slave address map.
// Shared by the write- and read-side routing controllers.
//   addr : address to decode
//   hit  : address maps to slave 0 or slave 1
//   sel  : selected slave index (0 when slave 0 hits or nothing hits)
// When both windows match, slave 0 takes priority.
// -----------------------------------------------------------------------------
module axi_addr_decode_2s #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK    = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK    = 32'hF000_0000
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic                  sel
);

  logic s0_hit;
  logic s1_hit;

  assign s0_hit = ((addr & S0_MASK) == S0_BASE);
  assign s1_hit = ((addr & S1_MASK) == S1_BASE);

  assign hit = s0_hit | s1_hit;
  assign sel = ~s0_hit & s1_hit;

endmodule

// File: rtl/axi_wr_route_ctrl.sv
// -----------------------------------------------------------------------------
// axi_wr_route_ctrl
// Write-channel routing controller for a 1-master / 2-slave AXI4 write path.
// Decodes AWADDR once per transaction, steers the external AW/W demuxes via
// route_sel, sequences the AW, W and B handshakes to the selected slave and
// answers unmapped addresses itself with DECERR. One transaction in flight.
//   ACLK, ARESETN              : clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*            : master-side write port handshakes
//   m_aw*/m_w*/m_b* [1:0]      : per-slave handshakes, bit i = slave i
//   m_bresp [3:0]              : per-slave B response, [2i+1:2i] = slave i
//   route_sel                  : demux select, 0 = slave 0
//   busy                       : a transaction is in progress
//   txn_count / decerr_count   : wrapping B-handshake / DECERR counters
// -----------------------------------------------------------------------------
module axi_wr_route_ctrl
  import axi_ic_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK    = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK    = 32'hF000_0000,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic                  s_wvalid,
  input  logic                  s_wlast,
  output logic                  s_wready,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  output logic [1:0]            m_awvalid,
  input  logic [1:0]            m_awready,
  output logic [1:0]            m_wvalid,
  input  logic [1:0]            m_wready,
  input  logic [1:0]            m_bvalid,
  output logic [1:0]            m_bready,
  input  logic [3:0]            m_bresp,
  output logic                  route_sel,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  txn_count,
  output logic [CNT_WIDTH-1:0]  decerr_count
);

  wr_route_state_t state, state_nxt;

  logic                 route_sel_q;
  logic                 tgt_err_q;
  logic [CNT_WIDTH-1:0] txn_q;
  logic [CNT_WIDTH-1:0] decerr_q;
  logic                 dec_hit;
  logic                 dec_sel;
  logic                 b_hs;

  axi_addr_decode_2s #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .S0_BASE    (S0_BASE),
    .S0_MASK    (S0_MASK),
    .S1_BASE    (S1_BASE),
    .S1_MASK    (S1_MASK)
  ) u_decode (
    .addr (s_awaddr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign b_hs = (state == RESP) & s_bvalid & s_bready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: default assignment first so no path through the case leaves
  // state_nxt unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_awvalid)                      state_nxt = ADDR;
      ADDR:    if (s_awvalid && s_awready)         state_nxt = DATA;
      DATA:    if (s_wvalid && s_wready && s_wlast) state_nxt = RESP;
      RESP:    if (b_hs)                           state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  // Decode is captured in IDLE so route_sel stays frozen from ADDR to RESP,
  // even if s_awaddr changes after the AW handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      route_sel_q <= 1'b0;
      tgt_err_q   <= 1'b0;
      txn_q       <= '0;
      decerr_q    <= '0;
    end else begin
      if (state == IDLE && s_awvalid) begin
        route_sel_q <= dec_sel;
        tgt_err_q   <= ~dec_hit;
      end
      if (b_hs) begin
        txn_q     <= txn_q + 1'b1;
        if (tgt_err_q) begin
          decerr_q <= decerr_q + 1'b1;
        end
        tgt_err_q <= 1'b0;
      end
    end
  end

  // Handshake signals are only live in their owning phase; the unselected
  // slave and any stray slave B response are never acknowledged.
  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    m_awvalid = 2'b00;
    m_wvalid  = 2'b00;
    m_bready  = 2'b00;
    case (state)
      ADDR: begin
        if (tgt_err_q) begin
          s_awready = 1'b1;
        end else begin
          m_awvalid[route_sel_q] = 1'b1;
          s_awready              = m_awready[route_sel_q];
        end
      end
      DATA: begin
        if (tgt_err_q) begin
          s_wready = 1'b1;
        end else begin
          m_wvalid[route_sel_q] = s_wvalid;
          s_wready              = m_wready[route_sel_q];
        end
      end
      RESP: begin
        if (tgt_err_q) begin
          s_bvalid = 1'b1;
          s_bresp  = RESP_DECERR;
        end else begin
          s_bvalid              = m_bvalid[route_sel_q];
          m_bready[route_sel_q] = s_bready;
          s_bresp               = route_sel_q ? m_bresp[3:2] : m_bresp[1:0];
        end
      end
      default: ;
    endcase
  end

  assign route_sel    = route_sel_q;
  assign busy         = (state != IDLE);
  assign txn_count    = txn_q;
  assign decerr_count = decerr_q;

endmodule

// File: tb/tb_axi_wr_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_route_ctrl
// Self-checking bench: a transaction-phase reference model predicts every
// output each cycle; directed scenarios add hand-computed expectations, then
// randomized transactions with random slave behaviour run against the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_wr_route_ctrl;

  localparam int CW = 4;

  logic          ACLK;
  logic          ARESETN;
  logic [31:0]   s_awaddr;
  logic          s_awvalid;
  logic          s_awready;
  logic          s_wvalid;
  logic          s_wlast;
  logic          s_wready;
  logic          s_bvalid;
  logic          s_bready;
  logic [1:0]    s_bresp;
  logic [1:0]    m_awvalid;
  logic [1:0]    m_awready;
  logic [1:0]    m_wvalid;
  logic [1:0]    m_wready;
  logic [1:0]    m_bvalid;
  logic [1:0]    m_bready;
  logic [3:0]    m_bresp;
  logic          route_sel;
  logic          busy;
  logic [CW-1:0] txn_count;
  logic [CW-1:0] decerr_count;

  axi_wr_route_ctrl #(.CNT_WIDTH(CW)) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .s_awaddr     (s_awaddr),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_wvalid     (s_wvalid),
    .s_wlast      (s_wlast),
    .s_wready     (s_wready),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .s_bresp      (s_bresp),
    .m_awvalid    (m_awvalid),
    .m_awready    (m_awready),
    .m_wvalid     (m_wvalid),
    .m_wready     (m_wready),
    .m_bvalid     (m_bvalid),
    .m_bready     (m_bready),
    .m_bresp      (m_bresp),
    .route_sel    (route_sel),
    .busy         (busy),
    .txn_count    (txn_count),
    .decerr_count (decerr_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 waiting for address, 1 address, 2 data, 3 response
  // tgt  : 0 / 1 = slave index, 2 = unmapped
  int   ph, tgt, txn_m, dec_m;
  logic rs;

  function automatic int decode(input logic [31:0] a);
    if (a[31:28] == 4'h0)      return 0;
    else if (a[31:28] == 4'h4) return 1;
    else                       return 2;
  endfunction

  typedef struct packed {
    logic          awready;
    logic          wready;
    logic          bvalid;
    logic [1:0]    bresp;
    logic [1:0]    m_awvalid;
    logic [1:0]    m_wvalid;
    logic [1:0]    m_bready;
    logic          route_sel;
    logic          busy;
    logic [CW-1:0] txn;
    logic [CW-1:0] dec;
  } outs_t;

  outs_t exp_o;

  always_comb begin
    exp_o           = '0;
    exp_o.route_sel = rs;
    exp_o.busy      = (ph != 0);
    exp_o.txn       = CW'(txn_m % (1 << CW));
    exp_o.dec       = CW'(dec_m % (1 << CW));
    if (ph == 1) begin
      if (tgt == 2) exp_o.awready = 1'b1;
      else begin
        exp_o.m_awvalid = 2'(1 << tgt);
        exp_o.awready   = m_awready[tgt];
      end
    end
    if (ph == 2) begin
      if (tgt == 2) exp_o.wready = 1'b1;
      else begin
        exp_o.m_wvalid = s_wvalid ? 2'(1 << tgt) : 2'b00;
        exp_o.wready   = m_wready[tgt];
      end
    end
    if (ph == 3) begin
      if (tgt == 2) begin
        exp_o.bvalid = 1'b1;
        exp_o.bresp  = 2'b11;
      end else begin
        exp_o.bvalid   = m_bvalid[tgt];
        exp_o.m_bready = s_bready ? 2'(1 << tgt) : 2'b00;
        exp_o.bresp    = m_bresp[2*tgt +: 2];
      end
    end
  end

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ph <= 0; tgt <= 0; rs <= 1'b0; txn_m <= 0; dec_m <= 0;
    end else begin
      case (ph)
        0: if (s_awvalid) begin
             tgt <= decode(s_awaddr);
             rs  <= (decode(s_awaddr) == 1);
             ph  <= 1;
           end
        1: if (s_awvalid && exp_o.awready) ph <= 2;
        2: if (s_wvalid && exp_o.wready && s_wlast) ph <= 3;
        3: if (exp_o.bvalid && s_bready) begin
             txn_m <= txn_m + 1;
             if (tgt == 2) dec_m <= dec_m + 1;
             ph <= 0;
           end
        default: ph <= 0;
      endcase
    end
  end

  // ---------------- per-cycle compare + activity monitor ----------------
  int w0_beats = 0, aw1_stall = 0, m_act = 0, wstall = 0, bstall = 0;
  logic [1:0] last_bresp = 2'b00;

  initial forever begin
    @(negedge ACLK);
    check("s_awready",    s_awready,    exp_o.awready);
    check("s_wready",     s_wready,     exp_o.wready);
    check("s_bvalid",     s_bvalid,     exp_o.bvalid);
    check("s_bresp",      s_bresp,      exp_o.bresp);
    check("m_awvalid",    m_awvalid,    exp_o.m_awvalid);
    check("m_wvalid",     m_wvalid,     exp_o.m_wvalid);
    check("m_bready",     m_bready,     exp_o.m_bready);
    check("route_sel",    route_sel,    exp_o.route_sel);
    check("busy",         busy,         exp_o.busy);
    check("txn_count",    txn_count,    exp_o.txn);
    check("decerr_count", decerr_count, exp_o.dec);
    if (m_wvalid[0] && m_wready[0])        w0_beats++;
    if (m_awvalid[1] && !m_awready[1])     aw1_stall++;
    if ((m_awvalid | m_wvalid | m_bready) != 2'b00) m_act++;
    if (s_wvalid && !s_wready)             wstall++;
    if (s_bvalid && !s_bready)             bstall++;
    if (s_bvalid && s_bready)              last_bresp = s_bresp;
  end

  // ---------------- slave-side driver ----------------
  bit rnd_slv = 1'b0;
  int aw_hold = 0;

  initial begin
    m_awready = 2'b00; m_wready = 2'b00; m_bvalid = 2'b00; m_bresp = 4'b0000;
    forever begin
      @(posedge ACLK); #1;
      if (rnd_slv) begin
        m_awready = 2'($urandom);
        m_wready  = 2'($urandom);
        m_bvalid  = 2'($urandom);
        m_bresp   = 4'($urandom);
      end else begin
        m_awready = (aw_hold > 0) ? 2'b00 : 2'b11;
        if (aw_hold > 0 && m_awvalid != 2'b00) aw_hold--;
        m_wready  = 2'b11;
        m_bvalid  = 2'b11;      // slave 1 also drives a stray B when unselected
        m_bresp   = 4'b0100;    // slave 0: OKAY, slave 1: EXOKAY
      end
    end
  end

  // ---------------- master-side transaction ----------------
  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic wait_ready(input string name, input int which);
    int n = 0;
    logic r;
    do begin
      @(negedge ACLK);
      n++;
      r = (which == 0) ? s_awready : (which == 1) ? s_wready : s_bvalid;
    end while (!r && n < 100);
    check(name, r, 1'b1);
    tick();
  endtask

  task automatic do_txn(input logic [31:0] addr, input int beats, input bit early_w,
                        input int bready_low, input int wgap);
    if (early_w) begin
      s_wvalid = 1'b1; s_wlast = (beats == 1);
      repeat (2) tick();
    end
    s_awaddr = addr; s_awvalid = 1'b1;
    wait_ready("aw_handshake", 0);
    s_awvalid = 1'b0; s_awaddr = $urandom;
    for (int b = 0; b < beats; b++) begin
      if (!(early_w && b == 0)) begin
        s_wvalid = 1'b0;
        repeat ($urandom_range(0, wgap)) tick();
        s_wvalid = 1'b1; s_wlast = (b == beats - 1);
      end
      wait_ready("w_handshake", 1);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    repeat (bready_low) tick();
    s_bready = 1'b1;
    wait_ready("b_handshake", 2);
    s_bready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return {4'h0, 28'($urandom)};
      1: return {4'h4, 28'($urandom)};
      2: return 32'h3FFF_FFFF;
      3: return 32'h4FFF_FFFF;
      4: return 32'h5000_0000;
      default: return $urandom;
    endcase
  endfunction

  int b0, b1, b2, b3, b4;

  initial begin
    ARESETN = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b0;
    repeat (3) @(posedge ACLK);
    #2;
    check("reset_outputs", {s_awready, s_wready, s_bvalid, s_bresp, m_awvalid, m_wvalid,
                            m_bready, route_sel, busy, txn_count, decerr_count}, 32'd0);
    tick();
    ARESETN = 1'b1;
    repeat (2) tick();

    // 4-beat write to slave 0
    b0 = w0_beats;
    do_txn(32'h0000_1000, 4, 1'b0, 0, 0);
    check("s1_w0_beats",   w0_beats - b0, 4);
    check("s1_bresp",      last_bresp,    2'b00);
    check("s1_txn_count",  txn_count,     4'd1);
    check("s1_route_sel",  route_sel,     1'b0);

    // slave 1 with AW stalled 3 cycles
    b1 = aw1_stall; b0 = w0_beats;
    aw_hold = 3;
    do_txn(32'h4000_0020, 1, 1'b0, 0, 0);
    check("s2_aw_stall",   aw1_stall - b1, 3);
    check("s2_route_sel",  route_sel,      1'b1);
    check("s2_bresp",      last_bresp,     2'b01);
    check("s2_w0_beats",   w0_beats - b0,  0);
    check("s2_txn_count",  txn_count,      4'd2);

    // unmapped address, 2 beats
    b2 = m_act;
    do_txn(32'h8000_0000, 2, 1'b0, 0, 0);
    check("s3_m_activity", m_act - b2,   0);
    check("s3_bresp",      last_bresp,   2'b11);
    check("s3_decerr",     decerr_count, 4'd1);
    check("s3_txn_count",  txn_count,    4'd3);
    check("s3_route_sel",  route_sel,    1'b0);

    // early W, then B held 5 cycles
    b3 = wstall; b4 = bstall;
    do_txn(32'h0000_0040, 1, 1'b1, 5, 0);
    check("s4_w_stall",    wstall - b3, 4);
    check("s4_b_stall",    bstall - b4, 5);
    check("s4_txn_count",  txn_count,   4'd4);

    // asynchronous reset mid-burst
    s_awaddr = 32'h0000_2000; s_awvalid = 1'b1;
    wait_ready("s5_aw_handshake", 0);
    s_awvalid = 1'b0; s_wvalid = 1'b1; s_wlast = 1'b0;
    @(negedge ACLK);
    check("s5_in_data", s_wready, 1'b1);
    @(posedge ACLK); #3;
    ARESETN = 1'b0;
    #1;
    check("s5_async_reset", {s_awready, s_wready, s_bvalid, s_bresp, m_awvalid, m_wvalid,
                             m_bready, route_sel, busy, txn_count, decerr_count}, 32'd0);
    s_wvalid = 1'b0;
    tick();
    ARESETN = 1'b1;
    tick();
    do_txn(32'h4000_0100, 2, 1'b0, 0, 1);
    check("s5_txn_count",  txn_count, 4'd1);
    check("s5_route_sel",  route_sel, 1'b1);
    check("s5_bresp",      last_bresp, 2'b01);

    // 16 more transactions: 17 since reset, counter wraps to 1
    rnd_slv = 1'b1;
    for (int i = 0; i < 16; i++)
      do_txn(rand_addr(), $urandom_range(1, 4), 1'b0, $urandom_range(0, 2), 1);
    check("wrap_txn_count", txn_count, 4'd1);

    // randomized soak against the model
    for (int i = 0; i < 60; i++)
      do_txn(rand_addr(), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 2);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
